// File: rtl/pusch_descrambler.sv
// PUSCH soft-bit descrambler.
// Regenerates the length-31 Gold sequence c(n) from RNTI / RAPID / cell-ID,
// sign-flips (with saturation) every incoming LLR where c(n)=1 and streams
// E descrambled LLRs per codeword under valid/ready flow control.
// Optional build macro: PUSCH_DESC_HARD_BIT_EN adds a registered hard_bit
// output (1 when the descrambled LLR is negative).
module pusch_descrambler #(
  parameter int LLR_W = 8,
  parameter int NC    = 1600
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    Config,
  input  logic [15:0]             N_Rnti,
  input  logic [5:0]              N_Rapid,
  input  logic [9:0]              N_cell_ID,
  input  logic [16:0]             E,
  input  logic signed [LLR_W-1:0] llr_in,
  input  logic                    llr_valid,
  output logic                    llr_ready,
  output logic signed [LLR_W-1:0] llr_out,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef PUSCH_DESC_HARD_BIT_EN
  output logic                    hard_bit,
`endif
  output logic                    done
);

  localparam int WCNT_W = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(NC - 1);
  localparam logic signed [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};
  localparam logic signed [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t                  state_q;
  logic [30:0]             x1_q, x2_q;
  logic [WCNT_W-1:0]       warm_q;
  logic [16:0]             in_cnt_q, e_q;
  logic signed [LLR_W-1:0] llr_out_q;
  logic                    out_valid_q, done_q;
`ifdef PUSCH_DESC_HARD_BIT_EN
  logic                    hard_q;
`endif

  logic [30:0]             cinit_d, x1_d, x2_d;
  logic                    c_bit, accept, out_hs, last_beat;
  logic signed [LLR_W-1:0] neg_llr, desc_llr;

  // c_init, wrapped to 31 bits (RNTI upper bits fall off the top)
  always_comb begin
    cinit_d = 31'd0;
    if (Config)
      cinit_d = {N_Rnti[14:0], 16'b0} + {15'b0, N_Rapid, 10'b0} + {21'b0, N_cell_ID};
    else
      cinit_d = {N_Rnti, 15'b0} + {21'b0, N_cell_ID};
  end

  // Bit 0 holds x(n); one step shifts right and appends x(n+31) on top
  assign x1_d  = {x1_q[3] ^ x1_q[0], x1_q[30:1]};
  assign x2_d  = {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
  assign c_bit = x1_q[0] ^ x2_q[0];

  // Negating the most negative LLR would wrap, so clamp it to the max
  assign neg_llr  = (llr_in == LLR_MIN) ? LLR_MAX : -llr_in;
  assign desc_llr = c_bit ? neg_llr : llr_in;

  assign llr_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept    = llr_valid && llr_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign last_beat = ((in_cnt_q + 17'd1) == e_q);

  // Control FSM, sequence generators and the registered output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x1_q        <= '0;
      x2_q        <= '0;
      warm_q      <= '0;
      in_cnt_q    <= '0;
      e_q         <= '0;
      llr_out_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PUSCH_DESC_HARD_BIT_EN
      hard_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (out_hs) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // E=0 is not a codeword; such a start is dropped
          if (start && (E != 17'd0)) begin
            e_q      <= E;
            x1_q     <= 31'h1;
            x2_q     <= cinit_d;
            warm_q   <= '0;
            in_cnt_q <= '0;
            state_q  <= S_WARMUP;
          end
        end
        S_WARMUP: begin
          x1_q   <= x1_d;
          x2_q   <= x2_d;
          warm_q <= warm_q + WCNT_W'(1);
          if (warm_q == WARM_LAST) state_q <= S_RUN;
        end
        S_RUN: begin
          if (accept) begin
            // overrides the handshake clear above: back-to-back, no bubble
            llr_out_q   <= desc_llr;
            out_valid_q <= 1'b1;
`ifdef PUSCH_DESC_HARD_BIT_EN
            hard_q      <= desc_llr[LLR_W-1];
`endif
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            in_cnt_q    <= in_cnt_q + 17'd1;
            if (last_beat) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign llr_out   = llr_out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
`ifdef PUSCH_DESC_HARD_BIT_EN
  assign hard_bit  = hard_q;
`endif

endmodule
